// File: rtl/axi4_wb_drop_responder.sv
// axi4_wb_drop_responder
// Routes slave W bursts to the master or swallows them, following in-order
// AW decisions. Each swallowed burst produces one injected SLVERR B response,
// which is merged into the slave B channel without ever preempting or losing
// a master B response.
module axi4_wb_drop_responder #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ID_WIDTH   = 4,
   parameter int C_AXI_USER_WIDTH = 4,
   parameter int C_DEC_DEPTH      = 4,
   parameter int C_BRESP_DEPTH    = 2
) (
   input  logic                          axi4_aclk,
   input  logic                          axi4_arst,
   input  logic [C_AXI_ID_WIDTH-1:0]     trans_id,
   input  logic                          trans_accept,
   input  logic                          trans_drop,
   output logic                          trans_ready,
   input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
   input  logic                          s_axi4_wlast,
   input  logic [C_AXI_USER_WIDTH-1:0]   s_axi4_wuser,
   input  logic                          s_axi4_wvalid,
   output logic                          s_axi4_wready,
   output logic [C_AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
   output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
   output logic                          m_axi4_wlast,
   output logic [C_AXI_USER_WIDTH-1:0]   m_axi4_wuser,
   output logic                          m_axi4_wvalid,
   input  logic                          m_axi4_wready,
   input  logic [C_AXI_ID_WIDTH-1:0]     m_axi4_bid,
   input  logic [1:0]                    m_axi4_bresp,
   input  logic [C_AXI_USER_WIDTH-1:0]   m_axi4_buser,
   input  logic                          m_axi4_bvalid,
   output logic                          m_axi4_bready,
   output logic [C_AXI_ID_WIDTH-1:0]     s_axi4_bid,
   output logic [1:0]                    s_axi4_bresp,
   output logic [C_AXI_USER_WIDTH-1:0]   s_axi4_buser,
   output logic                          s_axi4_bvalid,
   input  logic                          s_axi4_bready
);

   localparam int DAW = $clog2(C_DEC_DEPTH);
   localparam int BAW = $clog2(C_BRESP_DEPTH);
   localparam logic [DAW:0] DPTR_ONE = {{DAW{1'b0}}, 1'b1};
   localparam logic [BAW:0] BPTR_ONE = {{BAW{1'b0}}, 1'b1};
   localparam logic [1:0]   RESP_SLVERR = 2'b10;

   // Decision FIFO: entry = {drop, id}
   logic [C_AXI_ID_WIDTH:0]   dec_mem [C_DEC_DEPTH];
   logic [DAW:0]              dec_wptr, dec_rptr;
   logic                      dec_empty, dec_full, dec_push, dec_pop;
   logic [C_AXI_ID_WIDTH:0]   dec_head;
   logic                      head_drop;

   // Injected-B FIFO: entry = id of a swallowed burst
   logic [C_AXI_ID_WIDTH-1:0] b_mem [C_BRESP_DEPTH];
   logic [BAW:0]              b_wptr, b_rptr;
   logic                      b_empty, b_full, b_push, b_pop;
   logic [C_AXI_ID_WIDTH-1:0] b_head;

   logic                      injecting;

   // Equal index bits with differing wrap bits means the FIFO is full
   assign dec_empty = (dec_wptr == dec_rptr);
   assign dec_full  = (dec_wptr[DAW] != dec_rptr[DAW]) &&
                      (dec_wptr[DAW-1:0] == dec_rptr[DAW-1:0]);
   assign b_empty   = (b_wptr == b_rptr);
   assign b_full    = (b_wptr[BAW] != b_rptr[BAW]) &&
                      (b_wptr[BAW-1:0] == b_rptr[BAW-1:0]);

   assign trans_ready = !dec_full;
   assign dec_push    = (trans_accept | trans_drop) & !dec_full;
   assign dec_head    = dec_mem[dec_rptr[DAW-1:0]];
   assign head_drop   = dec_head[C_AXI_ID_WIDTH];
   assign b_head      = b_mem[b_rptr[BAW-1:0]];
   assign b_pop       = injecting & s_axi4_bready;

   // W payload is a pure passthrough; only valid/ready are gated
   assign m_axi4_wdata = s_axi4_wdata;
   assign m_axi4_wstrb = s_axi4_wstrb;
   assign m_axi4_wlast = s_axi4_wlast;
   assign m_axi4_wuser = s_axi4_wuser;

   // Decision storage; a simultaneous accept+drop is recorded as a drop
   always_ff @(posedge axi4_aclk) begin
      if (dec_push) dec_mem[dec_wptr[DAW-1:0]] <= {trans_drop, trans_id};
   end

   // Injected-B id storage, written on the handshake of a dropped wlast
   always_ff @(posedge axi4_aclk) begin
      if (b_push) b_mem[b_wptr[BAW-1:0]] <= dec_head[C_AXI_ID_WIDTH-1:0];
   end

   // FIFO pointers and injection flag
   always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
      if (axi4_arst) begin
         dec_wptr  <= {(DAW+1){1'b0}};
         dec_rptr  <= {(DAW+1){1'b0}};
         b_wptr    <= {(BAW+1){1'b0}};
         b_rptr    <= {(BAW+1){1'b0}};
         injecting <= 1'b0;
      end else begin
         if (dec_push) dec_wptr <= dec_wptr + DPTR_ONE;
         if (dec_pop)  dec_rptr <= dec_rptr + DPTR_ONE;
         if (b_push)   b_wptr   <= b_wptr + BPTR_ONE;
         if (b_pop)    b_rptr   <= b_rptr + BPTR_ONE;
         // Start only when the master B channel is idle so its response is never lost
         if (injecting) begin
            if (s_axi4_bready) injecting <= 1'b0;
         end else if (!b_empty && !m_axi4_bvalid) begin
            injecting <= 1'b1;
         end
      end
   end

   // W routing from the decision FIFO head
   always_comb begin
      m_axi4_wvalid = 1'b0;
      s_axi4_wready = 1'b0;
      dec_pop       = 1'b0;
      b_push        = 1'b0;
      if (dec_empty) begin
         m_axi4_wvalid = 1'b0;
      end else if (!head_drop) begin
         m_axi4_wvalid = s_axi4_wvalid;
         s_axi4_wready = m_axi4_wready;
         dec_pop       = s_axi4_wvalid & m_axi4_wready & s_axi4_wlast;
      end else begin
         // The last dropped beat stalls until there is room to queue its B
         s_axi4_wready = s_axi4_wlast ? !b_full : 1'b1;
         dec_pop       = s_axi4_wvalid & s_axi4_wlast & !b_full;
         b_push        = s_axi4_wvalid & s_axi4_wlast & !b_full;
      end
   end

   // B merge: injected SLVERR owns the slave B channel while active
   always_comb begin
      s_axi4_bid    = m_axi4_bid;
      s_axi4_bresp  = m_axi4_bresp;
      s_axi4_buser  = m_axi4_buser;
      s_axi4_bvalid = m_axi4_bvalid;
      m_axi4_bready = s_axi4_bready;
      if (injecting) begin
         s_axi4_bid    = b_head;
         s_axi4_bresp  = RESP_SLVERR;
         s_axi4_buser  = {C_AXI_USER_WIDTH{1'b0}};
         s_axi4_bvalid = 1'b1;
         m_axi4_bready = 1'b0;
      end else begin
         m_axi4_bready = s_axi4_bready;
      end
   end

endmodule

// File: tb/tb_axi4_wb_drop_responder.sv
// Directed bench for axi4_wb_drop_responder with a queue-based scoreboard:
// stimulus pushes expected master-W beats and slave-B responses, and a
// monitor pops and compares them on every observed handshake.
module tb_axi4_wb_drop_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  trans_id = 4'h0;
   logic        trans_accept = 1'b0, trans_drop = 1'b0, trans_ready;
   logic [31:0] s_wdata = 32'h0;
   logic [3:0]  s_wstrb = 4'h0, s_wuser = 4'h0;
   logic        s_wlast = 1'b0, s_wvalid = 1'b0, s_wready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb, m_wuser;
   logic        m_wlast, m_wvalid, m_wready = 1'b0;
   logic [3:0]  m_bid = 4'h0, m_buser = 4'h0;
   logic [1:0]  m_bresp = 2'b00;
   logic        m_bvalid = 1'b0, m_bready;
   logic [3:0]  s_bid, s_buser;
   logic [1:0]  s_bresp;
   logic        s_bvalid, s_bready = 1'b0;

   typedef struct packed { logic [31:0] data; logic [3:0] strb; logic [3:0] user; logic last; } wbeat_t;
   typedef struct packed { logic [3:0] id; logic [1:0] resp; logic [3:0] user; } bresp_t;
   wbeat_t exp_w[$];
   bresp_t exp_b[$];
   int n_vec = 0;
   int n_err = 0;

   axi4_wb_drop_responder dut (
      .axi4_aclk(clk), .axi4_arst(rst),
      .trans_id(trans_id), .trans_accept(trans_accept), .trans_drop(trans_drop),
      .trans_ready(trans_ready),
      .s_axi4_wdata(s_wdata), .s_axi4_wstrb(s_wstrb), .s_axi4_wlast(s_wlast),
      .s_axi4_wuser(s_wuser), .s_axi4_wvalid(s_wvalid), .s_axi4_wready(s_wready),
      .m_axi4_wdata(m_wdata), .m_axi4_wstrb(m_wstrb), .m_axi4_wlast(m_wlast),
      .m_axi4_wuser(m_wuser), .m_axi4_wvalid(m_wvalid), .m_axi4_wready(m_wready),
      .m_axi4_bid(m_bid), .m_axi4_bresp(m_bresp), .m_axi4_buser(m_buser),
      .m_axi4_bvalid(m_bvalid), .m_axi4_bready(m_bready),
      .s_axi4_bid(s_bid), .s_axi4_bresp(s_bresp), .s_axi4_buser(s_buser),
      .s_axi4_bvalid(s_bvalid), .s_axi4_bready(s_bready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next n rising edges (the input drive phase)
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic decide(input logic [3:0] id, input logic drop);
      trans_id = id;
      trans_accept = !drop;
      trans_drop = drop;
      tick(1);
      trans_accept = 1'b0;
      trans_drop = 1'b0;
   endtask

   // Present one beat and hold it until accepted (bounded wait)
   task automatic send_beat(input logic [31:0] d, input logic [3:0] strb, input logic [3:0] user,
                            input logic last, input logic drop);
      logic done;
      s_wdata = d; s_wstrb = strb; s_wuser = user; s_wlast = last; s_wvalid = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (s_wready) done = 1'b1;
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL w_accept_timeout: got s_wready=0 expected 1 for data %0h", d);
      end else if (drop) begin
         check("drop_mwvalid", {63'd0, m_wvalid}, 64'd0);
      end
      @(posedge clk); #1;
      s_wvalid = 1'b0;
      s_wlast = 1'b0;
   endtask

   // Monitor: compare every master W and slave B handshake against the queues
   always @(negedge clk) begin
      if (!rst) begin
         if (m_wvalid && m_wready) begin
            if (exp_w.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL w_unexpected: got beat data %0h expected none", m_wdata);
            end else begin
               wbeat_t e;
               e = exp_w.pop_front();
               check("m_w_beat", {23'd0, m_wdata, m_wstrb, m_wuser, m_wlast}, {23'd0, e});
            end
         end
         if (s_bvalid && s_bready) begin
            if (exp_b.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL b_unexpected: got bid %0h resp %0h expected none", s_bid, s_bresp);
            end else begin
               bresp_t e;
               e = exp_b.pop_front();
               check("s_b_resp", {54'd0, s_bid, s_bresp, s_buser}, {54'd0, e});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(3);
      @(negedge clk);
      check("rst_s_wready", {63'd0, s_wready}, 64'd0);
      check("rst_m_wvalid", {63'd0, m_wvalid}, 64'd0);
      check("rst_s_bvalid", {63'd0, s_bvalid}, 64'd0);
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_trans_ready", {63'd0, trans_ready}, 64'd1);
      tick(1);

      // Accept id=3, 4-beat burst forwarded
      m_wready = 1'b1; s_bready = 1'b1;
      decide(4'd3, 1'b0);
      for (int i = 0; i < 4; i++) exp_w.push_back({32'hA000_0000 + 32'(i), 4'hF, 4'h5, (i == 3)});
      for (int i = 0; i < 4; i++) send_beat(32'hA000_0000 + 32'(i), 4'hF, 4'h5, (i == 3), 1'b0);
      @(negedge clk);
      check("acc_fifo_empty", {63'd0, s_wready}, 64'd0);
      tick(3);

      // Drop id=5, 3-beat burst; injected B held with s_bready=0
      s_bready = 1'b0;
      decide(4'd5, 1'b1);
      for (int i = 0; i < 3; i++) send_beat(32'h5555_0000 + 32'(i), 4'hF, 4'h2, (i == 2), 1'b1);
      @(negedge clk);
      check("inj_not_yet", {63'd0, s_bvalid}, 64'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("inj_hold", {54'd0, s_bvalid, s_bid, s_bresp, s_buser}, {54'd0, 1'b1, 4'd5, 2'b10, 4'd0});
      end
      tick(1);
      exp_b.push_back({4'd5, 2'b10, 4'd0});
      s_bready = 1'b1;
      tick(3);

      // Drop id=2 while master B (id 7, OKAY) is pending
      s_bready = 1'b0;
      m_bvalid = 1'b1; m_bid = 4'd7; m_bresp = 2'b00; m_buser = 4'h3;
      decide(4'd2, 1'b1);
      send_beat(32'h2222_0000, 4'hF, 4'h0, 1'b1, 1'b1);
      tick(2);
      @(negedge clk);
      check("mb_first", {57'd0, s_bvalid, s_bid, s_bresp}, {57'd0, 1'b1, 4'd7, 2'b00});
      tick(1);
      exp_b.push_back({4'd7, 2'b00, 4'h3});
      exp_b.push_back({4'd2, 2'b10, 4'd0});
      s_bready = 1'b1;
      tick(1);
      m_bvalid = 1'b0;
      @(negedge clk);
      check("inj_after_mb", {63'd0, s_bvalid}, 64'd0);
      tick(4);

      // Interleaved accept 1, drop 6, accept 9 with 2-beat bursts
      decide(4'd1, 1'b0);
      decide(4'd6, 1'b1);
      decide(4'd9, 1'b0);
      for (int i = 0; i < 2; i++) exp_w.push_back({32'h1111_0000 + 32'(i), 4'hF, 4'h1, (i == 1)});
      for (int i = 0; i < 2; i++) exp_w.push_back({32'h9999_0000 + 32'(i), 4'h3, 4'h9, (i == 1)});
      exp_b.push_back({4'd6, 2'b10, 4'd0});
      for (int i = 0; i < 2; i++) send_beat(32'h1111_0000 + 32'(i), 4'hF, 4'h1, (i == 1), 1'b0);
      for (int i = 0; i < 2; i++) send_beat(32'h6666_0000 + 32'(i), 4'hC, 4'h6, (i == 1), 1'b1);
      for (int i = 0; i < 2; i++) send_beat(32'h9999_0000 + 32'(i), 4'h3, 4'h9, (i == 1), 1'b0);
      tick(5);

      // Fill the decision FIFO, then back up the injected-B FIFO
      s_bready = 1'b0;
      for (int i = 0; i < 4; i++) decide(4'd10 + 4'(i), 1'b1);
      @(negedge clk);
      check("dec_full_ready", {63'd0, trans_ready}, 64'd0);
      tick(1);
      send_beat(32'hB000_000A, 4'hF, 4'h0, 1'b1, 1'b1);
      send_beat(32'hB000_000B, 4'hF, 4'h0, 1'b1, 1'b1);
      s_wdata = 32'hB000_000C; s_wlast = 1'b1; s_wvalid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bfull_stall", {63'd0, s_wready}, 64'd0);
      end
      tick(1);
      for (int i = 0; i < 4; i++) exp_b.push_back({4'd10 + 4'(i), 2'b10, 4'd0});
      s_bready = 1'b1;
      send_beat(32'hB000_000C, 4'hF, 4'h0, 1'b1, 1'b1);
      @(negedge clk);
      check("dec_ready_again", {63'd0, trans_ready}, 64'd1);
      tick(1);
      send_beat(32'hB000_000D, 4'hF, 4'h0, 1'b1, 1'b1);
      tick(10);

      // Reset during an injection and a stalled accepted burst
      s_bready = 1'b0;
      decide(4'd8, 1'b1);
      send_beat(32'h8888_0000, 4'hF, 4'h0, 1'b1, 1'b1);
      decide(4'd4, 1'b0);
      exp_w.push_back({32'h4444_0000, 4'hF, 4'h4, 1'b0});
      send_beat(32'h4444_0000, 4'hF, 4'h4, 1'b0, 1'b0);
      m_wready = 1'b0;
      s_wdata = 32'h4444_0001; s_wstrb = 4'hF; s_wuser = 4'h4; s_wlast = 1'b1; s_wvalid = 1'b1;
      tick(1);
      @(negedge clk);
      check("pre_rst_state", {62'd0, s_bvalid, m_wvalid}, {62'd0, 1'b1, 1'b1});
      #1;
      rst = 1'b1;
      #2;
      check("rst_async_out", {61'd0, s_bvalid, m_wvalid, s_wready}, 64'd0);
      tick(2);
      s_wvalid = 1'b0; s_wlast = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {62'd0, trans_ready, s_wready}, {62'd0, 1'b1, 1'b0});
      tick(1);
      s_bready = 1'b1; m_wready = 1'b1;
      tick(6);

      check("exp_w_drained", 64'(exp_w.size()), 64'd0);
      check("exp_b_drained", 64'(exp_b.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
